// File: rtl/change_dispenser.sv
`timescale 1ns/1ps
// change_dispenser: pays out change or refunds from the vending controller as
// a greedy sequence of single-coin requests to the hopper. Each coin is a
// one-hot coin_out request held until hopper_ack. Running total, completion
// and fault pulses are reported back.
module change_dispenser #(
  parameter int DENO_5      = 5,   // value of coin_out[0]
  parameter int DENO_10     = 10,  // value of coin_out[1]
  parameter int DENO_20     = 20,  // value of coin_out[2]
  parameter int ACK_TIMEOUT = 16   // max cycles a request waits for ack (>= 2)
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       done,
  input  logic       end_trans,
  input  logic [7:0] sum_money,
  input  logic [7:0] price,
  input  logic       hopper_ack,
  output logic [2:0] coin_out,
  output logic       busy,
  output logic [7:0] change_total,
  output logic       change_done,
  output logic       error
);

  localparam int              CNT_W    = $clog2(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  localparam logic [7:0] VAL_5  = 8'(DENO_5);
  localparam logic [7:0] VAL_10 = 8'(DENO_10);
  localparam logic [7:0] VAL_20 = 8'(DENO_20);

  localparam logic [2:0] COIN_NONE = 3'b000;
  localparam logic [2:0] COIN_5    = 3'b001;
  localparam logic [2:0] COIN_10   = 3'b010;
  localparam logic [2:0] COIN_20   = 3'b100;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,  // waiting for done / end_trans
    SELECT = 3'd1,  // choose the largest coin that still fits
    ISSUE  = 3'd2,  // hold the coin request until the hopper acks
    FIN    = 3'd3,  // completion pulse (plus error on a residue)
    FAULT  = 3'd4   // underpay or hopper timeout
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       coin_q, coin_d;
  logic [7:0]       remaining_q, remaining_d;
  logic [7:0]       total_q, total_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       coin_value;

  // Value of the coin currently being requested.
  always_comb begin
    coin_value = 8'd0;
    unique case (coin_q)
      COIN_5:  coin_value = VAL_5;
      COIN_10: coin_value = VAL_10;
      COIN_20: coin_value = VAL_20;
      default: coin_value = 8'd0;
    endcase
  end

  // Next-state logic for the payout FSM and its datapath registers.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case statement leaves one unassigned, which would infer a latch.
    state_d     = state_q;
    coin_d      = coin_q;
    remaining_d = remaining_q;
    total_d     = total_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      IDLE: begin
        coin_d = COIN_NONE;
        if (done) begin
          // done wins over end_trans; total clears even on the fault path.
          total_d = 8'd0;
          if (price > sum_money) begin
            state_d = FAULT;
          end else begin
            remaining_d = sum_money - price;
            state_d     = SELECT;
          end
        end else if (end_trans) begin
          total_d     = 8'd0;
          remaining_d = sum_money;
          state_d     = SELECT;
        end
      end

      SELECT: begin
        cnt_d   = '0;
        state_d = ISSUE;
        if (remaining_q >= VAL_20) begin
          coin_d = COIN_20;
        end else if (remaining_q >= VAL_10) begin
          coin_d = COIN_10;
        end else if (remaining_q >= VAL_5) begin
          coin_d = COIN_5;
        end else begin
          coin_d  = COIN_NONE;
          state_d = FIN;
        end
      end

      ISSUE: begin
        if (hopper_ack) begin
          // Dropping the request here guarantees an idle cycle (SELECT)
          // between consecutive coins.
          remaining_d = remaining_q - coin_value;
          total_d     = total_q + coin_value;
          coin_d      = COIN_NONE;
          state_d     = SELECT;
        end else if (cnt_q == CNT_LAST) begin
          coin_d  = COIN_NONE;
          state_d = FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      FIN: begin
        remaining_d = 8'd0;
        state_d     = IDLE;
      end

      FAULT: begin
        coin_d      = COIN_NONE;
        remaining_d = 8'd0;
        state_d     = IDLE;
      end

      default: begin
        coin_d  = COIN_NONE;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; async reset also drops coin_out at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      coin_q      <= COIN_NONE;
      remaining_q <= 8'd0;
      total_q     <= 8'd0;
      cnt_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      coin_q      <= coin_d;
      remaining_q <= remaining_d;
      total_q     <= total_d;
      cnt_q       <= cnt_d;
    end
  end

  // Moore outputs decoded from the registered state.
  assign coin_out     = coin_q;
  assign change_total = total_q;
  assign busy         = (state_q == SELECT) || (state_q == ISSUE);
  assign change_done  = (state_q == FIN);
  assign error        = (state_q == FAULT) ||
                        ((state_q == FIN) && (remaining_q != 8'd0));

endmodule
